keypad_emulator: RTL and testbench

Synthesizable 4x4 matrix-keypad model: the responder side of the keypad scanning interface. It watches the column lines driven by the scanner FSM and drives the row lines back as a real keypad would, with programmable contact bounce, hold time and release gap. It is used in simulation benches and on hardware loopback builds to exercise the scanner, synchronizer, debouncer and keypad decoder without a physical keypad.

---
 rtl/keypad_emulator.sv | 190 +++++++++++++++++++
 tb/tb_keypad_emulator.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// keypad_emulator: responder side of a 4x4 matrix keypad.
// Watches the scanner's column drive and returns the pressed key's row,
// with LFSR-driven contact chatter on press/release, a programmable hold
// time and an open-contact gap before the next press is accepted.
module keypad_emulator #(
  parameter int unsigned BOUNCE_CYCLES = 16,
  parameter int unsigned GAP_CYCLES    = 64,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  col_keys,
  output logic [3:0]  row_keys,
  input  logic        press_valid,
  input  logic [3:0]  press_key,
  input  logic [15:0] press_hold,
  output logic        press_ready,
  output logic        busy,
  output logic        contact
);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_PRESS_BOUNCE = 3'd1;
  localparam logic [2:0] S_HELD         = 3'd2;
  localparam logic [2:0] S_REL_BOUNCE   = 3'd3;
  localparam logic [2:0] S_GAP          = 3'd4;

  localparam logic [15:0] BOUNCE_LOAD = 16'(BOUNCE_CYCLES);
  // A zero gap would let the next press land with no open-contact interval.
  localparam logic [15:0] GAP_LOAD    = (GAP_CYCLES < 1) ? 16'd1 : 16'(GAP_CYCLES);
  localparam bit          HAS_BOUNCE  = (BOUNCE_CYCLES != 0);

  // Returns {row, col} for a hex key value.
  function automatic logic [3:0] key_pos(input logic [3:0] key);
    logic [3:0] pos;
    case (key)
      4'h1:    pos = 4'b00_00;
      4'h2:    pos = 4'b00_01;
      4'h3:    pos = 4'b00_10;
      4'hA:    pos = 4'b00_11;
      4'h4:    pos = 4'b01_00;
      4'h5:    pos = 4'b01_01;
      4'h6:    pos = 4'b01_10;
      4'hB:    pos = 4'b01_11;
      4'h7:    pos = 4'b10_00;
      4'h8:    pos = 4'b10_01;
      4'h9:    pos = 4'b10_10;
      4'hC:    pos = 4'b10_11;
      4'hE:    pos = 4'b11_00;
      4'h0:    pos = 4'b11_01;
      4'hF:    pos = 4'b11_10;
      default: pos = 4'b11_11;  // key D
    endcase
    return pos;
  endfunction

  logic [2:0]  state_reg, state_next;
  logic [15:0] count_reg, count_next;
  logic        contact_reg, contact_next;
  logic [7:0]  lfsr_reg, lfsr_next;
  logic [7:0]  lfsr_step;
  logic [1:0]  row_sel_reg, col_sel_reg;
  logic [15:0] hold_reg;
  logic [15:0] hold_eff;
  logic [3:0]  row_reg;
  logic [3:0]  row_hit;
  logic        accept;

  assign accept    = press_valid && (state_reg == S_IDLE);
  assign hold_eff  = (press_hold == 16'd0) ? 16'd1 : press_hold;
  // Fibonacci x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  assign lfsr_step = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};

  // Next-state, shared down-counter, contact and LFSR advance.
  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    contact_next = contact_reg;
    lfsr_next    = lfsr_reg;
    case (state_reg)
      S_IDLE: begin
        contact_next = 1'b0;
        if (accept) begin
          if (HAS_BOUNCE) begin
            state_next   = S_PRESS_BOUNCE;
            count_next   = BOUNCE_LOAD;
            contact_next = lfsr_reg[0];
          end else begin
            state_next   = S_HELD;
            count_next   = hold_eff;
            contact_next = 1'b1;
          end
        end
      end
      S_PRESS_BOUNCE: begin
        lfsr_next = lfsr_step;
        if (count_reg == 16'd1) begin
          state_next   = S_HELD;
          count_next   = hold_reg;
          contact_next = 1'b1;
        end else begin
          count_next   = count_reg - 16'd1;
          contact_next = lfsr_step[0];
        end
      end
      S_HELD: begin
        if (count_reg == 16'd1) begin
          if (HAS_BOUNCE) begin
            state_next   = S_REL_BOUNCE;
            count_next   = BOUNCE_LOAD;
            contact_next = lfsr_reg[0];
          end else begin
            state_next   = S_GAP;
            count_next   = GAP_LOAD;
            contact_next = 1'b0;
          end
        end else begin
          count_next = count_reg - 16'd1;
        end
      end
      S_REL_BOUNCE: begin
        lfsr_next = lfsr_step;
        if (count_reg == 16'd1) begin
          state_next   = S_GAP;
          count_next   = GAP_LOAD;
          contact_next = 1'b0;
        end else begin
          count_next   = count_reg - 16'd1;
          contact_next = lfsr_step[0];
        end
      end
      S_GAP: begin
        contact_next = 1'b0;
        if (count_reg == 16'd1) begin
          state_next = S_IDLE;
          count_next = 16'd0;
        end else begin
          count_next = count_reg - 16'd1;
        end
      end
      default: begin
        state_next   = S_IDLE;
        count_next   = 16'd0;
        contact_next = 1'b0;
      end
    endcase
  end

  // State registers; key position and hold count are captured only on accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      count_reg   <= 16'd0;
      contact_reg <= 1'b0;
      lfsr_reg    <= LFSR_SEED;
      row_sel_reg <= 2'd0;
      col_sel_reg <= 2'd0;
      hold_reg    <= 16'd1;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      contact_reg <= contact_next;
      lfsr_reg    <= lfsr_next;
      if (accept) begin
        {row_sel_reg, col_sel_reg} <= key_pos(press_key);
        hold_reg                   <= hold_eff;
      end
    end
  end

  // Only the latched row can answer, and only while its column is driven.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign row_hit[gi] = contact_reg && (row_sel_reg == 2'(gi)) && col_keys[col_sel_reg];
    end
  endgenerate

  // Registered row return, one cycle behind contact/col_keys.
  always_ff @(posedge clk) begin
    if (!reset) row_reg <= 4'b0000;
    else        row_reg <= row_hit;
  end

  assign row_keys    = row_reg;
  assign contact     = contact_reg;
  assign press_ready = (state_reg == S_IDLE);
  assign busy        = (state_reg != S_IDLE);

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: one bounce-free instance (gap 4)
// and one bouncing instance (16 bounce cycles, gap 8).
module tb_keypad_emulator;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]  col0, row0, key0;
  logic        valid0, ready0, busy0, contact0;
  logic [15:0] hold0;
  logic [3:0]  col1, row1, key1;
  logic        valid1, ready1, busy1, contact1;
  logic [15:0] hold1;

  int checks = 0;
  int passed = 0;

  keypad_emulator #(.BOUNCE_CYCLES(0), .GAP_CYCLES(4), .LFSR_SEED(8'hA5)) dut0 (
    .clk(clk), .reset(reset), .col_keys(col0), .row_keys(row0),
    .press_valid(valid0), .press_key(key0), .press_hold(hold0),
    .press_ready(ready0), .busy(busy0), .contact(contact0));

  keypad_emulator #(.BOUNCE_CYCLES(16), .GAP_CYCLES(8), .LFSR_SEED(8'hA5)) dut1 (
    .clk(clk), .reset(reset), .col_keys(col1), .row_keys(row1),
    .press_valid(valid1), .press_key(key1), .press_hold(hold1),
    .press_ready(ready1), .busy(busy1), .contact(contact1));

  function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    col0 = 4'hF; col1 = 4'hF;
    valid0 = 1'b0; key0 = 4'h0; hold0 = 16'd0;
    valid1 = 1'b0; key1 = 4'h0; hold1 = 16'd0;
    step(); step();
    checks++; if ({row0, contact0, ready0, busy0} !== 7'b0000_0_1_0) $display("FAIL reset0 got=%b exp=%b", {row0, contact0, ready0, busy0}, 7'b0000_0_1_0); else passed++;
    checks++; if ({row1, contact1, ready1, busy1} !== 7'b0000_0_1_0) $display("FAIL reset1 got=%b exp=%b", {row1, contact1, ready1, busy1}, 7'b0000_0_1_0); else passed++;
    reset = 1'b1;
    col0 = 4'h0; col1 = 4'h0;
    step();
    $display("test_reset: done");
  endtask

  task automatic test_clean_press();
    logic prev_c, exp_c, exp_busy;
    logic [3:0] prev_col, exp_row;
    col0 = 4'b0001; valid0 = 1'b1; key0 = 4'h5; hold0 = 16'd10;
    prev_c = 1'b0; prev_col = col0;
    for (int n = 1; n <= 16; n++) begin
      step();
      if (n == 1) valid0 = 1'b0;
      exp_row  = (prev_c && prev_col[1]) ? 4'b0010 : 4'b0000;
      exp_c    = (n <= 10);
      exp_busy = (n <= 14);
      checks++; if (row0 !== exp_row) $display("FAIL clean_row n=%0d got=%b exp=%b", n, row0, exp_row); else passed++;
      checks++; if (contact0 !== exp_c) $display("FAIL clean_contact n=%0d got=%b exp=%b", n, contact0, exp_c); else passed++;
      checks++; if (busy0 !== exp_busy) $display("FAIL clean_busy n=%0d got=%b exp=%b", n, busy0, exp_busy); else passed++;
      checks++; if (ready0 !== !exp_busy) $display("FAIL clean_ready n=%0d got=%b exp=%b", n, ready0, !exp_busy); else passed++;
      prev_c   = exp_c;
      col0     = 4'b0001 << (n % 4);
      prev_col = col0;
    end
    $display("test_clean_press: key 5 hold 10 done");
  endtask

  task automatic test_bounce();
    logic [7:0] l;
    logic prev_c, exp_c, exp_busy;
    col1 = 4'b1000; valid1 = 1'b1; key1 = 4'hD; hold1 = 16'd100;
    l = 8'hA5; prev_c = 1'b0;
    for (int n = 1; n <= 141; n++) begin
      step();
      if (n == 1) valid1 = 1'b0;
      if (n <= 16) begin exp_c = l[0]; l = lfsr_adv(l); end
      else if (n <= 116) exp_c = 1'b1;
      else if (n <= 132) begin exp_c = l[0]; l = lfsr_adv(l); end
      else exp_c = 1'b0;
      exp_busy = (n <= 140);
      checks++; if (row1 !== {prev_c, 3'b000}) $display("FAIL bounce_row n=%0d got=%b exp=%b", n, row1, {prev_c, 3'b000}); else passed++;
      checks++; if (contact1 !== exp_c) $display("FAIL bounce_contact n=%0d got=%b exp=%b", n, contact1, exp_c); else passed++;
      checks++; if (busy1 !== exp_busy) $display("FAIL bounce_busy n=%0d got=%b exp=%b", n, busy1, exp_busy); else passed++;
      checks++; if (ready1 !== !exp_busy) $display("FAIL bounce_ready n=%0d got=%b exp=%b", n, ready1, !exp_busy); else passed++;
      prev_c = exp_c;
    end
    $display("test_bounce: key D hold 100 done");
  endtask

  task automatic test_hold_zero_busy();
    col0 = 4'b0010; valid0 = 1'b1; key0 = 4'h0; hold0 = 16'd0;
    step();
    valid0 = 1'b0;
    checks++; if ({contact0, busy0} !== 2'b11) $display("FAIL hold0_held got=%b exp=%b", {contact0, busy0}, 2'b11); else passed++;
    step();
    checks++; if (row0 !== 4'b1000) $display("FAIL hold0_row got=%b exp=%b", row0, 4'b1000); else passed++;
    checks++; if (contact0 !== 1'b0) $display("FAIL hold0_gap_contact got=%b exp=0", contact0); else passed++;
    valid0 = 1'b1; key0 = 4'hF; hold0 = 16'd2; col0 = 4'b0100;
    for (int n = 3; n <= 5; n++) begin
      step();
      checks++; if ({busy0, contact0} !== 2'b10) $display("FAIL busy_ignore n=%0d got=%b exp=%b", n, {busy0, contact0}, 2'b10); else passed++;
    end
    step();
    checks++; if ({ready0, busy0} !== 2'b10) $display("FAIL hold0_ready got=%b exp=%b", {ready0, busy0}, 2'b10); else passed++;
    step();
    valid0 = 1'b0;
    checks++; if ({busy0, contact0} !== 2'b11) $display("FAIL second_accept got=%b exp=%b", {busy0, contact0}, 2'b11); else passed++;
    step();
    checks++; if ({row0, contact0} !== 5'b1000_1) $display("FAIL second_key_row got=%b exp=%b", {row0, contact0}, 5'b1000_1); else passed++;
    step();
    checks++; if ({row0, contact0, busy0} !== 6'b1000_0_1) $display("FAIL second_release got=%b exp=%b", {row0, contact0, busy0}, 6'b1000_0_1); else passed++;
    for (int i = 0; i < 50 && !ready0; i++) step();
    checks++; if (ready0 !== 1'b1) $display("FAIL hold0_idle_timeout got=%b exp=1", ready0); else passed++;
    $display("test_hold_zero_busy: key 0 hold 0 then queued-by-requester key F done");
  endtask

  task automatic test_multi_hot();
    col0 = 4'b0000; valid0 = 1'b1; key0 = 4'h9; hold0 = 16'd20;
    step();
    valid0 = 1'b0;
    checks++; if (contact0 !== 1'b1) $display("FAIL mh_contact got=%b exp=1", contact0); else passed++;
    col0 = 4'b0110;
    step();
    checks++; if (row0 !== 4'b0100) $display("FAIL mh_0110 got=%b exp=%b", row0, 4'b0100); else passed++;
    col0 = 4'b1001;
    step();
    checks++; if (row0 !== 4'b0000) $display("FAIL mh_1001 got=%b exp=%b", row0, 4'b0000); else passed++;
    col0 = 4'b0100;
    step();
    checks++; if (row0 !== 4'b0100) $display("FAIL mh_0100 got=%b exp=%b", row0, 4'b0100); else passed++;
    for (int i = 0; i < 100 && !ready0; i++) step();
    checks++; if (ready0 !== 1'b1) $display("FAIL mh_idle_timeout got=%b exp=1", ready0); else passed++;
    $display("test_multi_hot: key 9 hold 20 done");
  endtask

  task automatic test_reset_mid_held();
    logic [7:0] l;
    col1 = 4'b1000; valid1 = 1'b1; key1 = 4'hA; hold1 = 16'd50;
    step();
    valid1 = 1'b0;
    for (int n = 2; n <= 20; n++) step();
    checks++; if ({row1, contact1} !== 5'b0001_1) $display("FAIL midheld_row got=%b exp=%b", {row1, contact1}, 5'b0001_1); else passed++;
    reset = 1'b0;
    step();
    checks++; if ({row1, contact1, ready1, busy1} !== 7'b0000_0_1_0) $display("FAIL midheld_reset got=%b exp=%b", {row1, contact1, ready1, busy1}, 7'b0000_0_1_0); else passed++;
    reset = 1'b1;
    valid1 = 1'b1; key1 = 4'hD; hold1 = 16'd1;
    l = 8'hA5;
    for (int n = 1; n <= 16; n++) begin
      step();
      if (n == 1) valid1 = 1'b0;
      checks++; if (contact1 !== l[0]) $display("FAIL reseed_contact n=%0d got=%b exp=%b", n, contact1, l[0]); else passed++;
      l = lfsr_adv(l);
    end
    for (int i = 0; i < 100 && !ready1; i++) step();
    checks++; if (ready1 !== 1'b1) $display("FAIL reseed_idle_timeout got=%b exp=1", ready1); else passed++;
    $display("test_reset_mid_held: key A reset in HELD, key D reseeded bounce done");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_zero_busy();
    test_multi_hot();
    test_reset_mid_held();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
